// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth (any depth >= 2), occupancy count,
// almost-full/almost-empty thresholds, sticky error flags and a registered read port.
module sync_fifo_param #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clear_err
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] CNT_AEMPT = CW'(AEMPTY_LEVEL);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] data_out_r;
    logic             data_valid_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic [CW-1:0]    count_nxt_s;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);

    // Acceptance and next-state arithmetic, all decoded from the registered count.
    always_comb begin
        pop_ok_s  = pop & ~empty_s;
        push_ok_s = push & (~full_s | pop_ok_s);

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // Explicit wrap compare so non-power-of-two depths work.
        if (wr_ptr_r == PTR_LAST) begin
            wr_ptr_nxt_s = PTR_ZERO;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end

        if (rd_ptr_r == PTR_LAST) begin
            rd_ptr_nxt_s = PTR_ZERO;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end
    end

    // Storage array: written on accepted push only, never reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy, read port and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            data_valid_r <= pop_ok_s;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_nxt_s;
            end
            if (pop_ok_s) begin
                rd_ptr_r   <= rd_ptr_nxt_s;
                data_out_r <= mem_r[rd_ptr_r];
            end
            // A new error in the same cycle as clear_err keeps the flag set.
            if (push && !push_ok_s) begin
                overflow_r <= 1'b1;
            end else if (clear_err) begin
                overflow_r <= 1'b0;
            end
            if (pop && !pop_ok_s) begin
                underflow_r <= 1'b1;
            end else if (clear_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign data_out     = data_out_r;
    assign data_valid   = data_valid_r;
    assign count        = count_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= CNT_AFULL);
    assign almost_empty = (count_r <= CNT_AEMPT);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
